// File: rtl/bus_sched_pkg.sv
// Shared types and helpers for the bus scheduling blocks: FSM state encoding,
// default widths, and a constant-foldable ceil(log2) usable in parameter expressions.
package bus_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } sched_state_e;

    localparam int unsigned DEF_N  = 4;
    localparam int unsigned DEF_CW = 4;
    localparam int unsigned DEF_TO = 15;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set bit of e scanning last+1,
// last+2, ... modulo N, so the previous winner has lowest priority.
module rr_pick
    import bus_sched_pkg::*;
#(
    parameter  int unsigned N  = DEF_N,
    localparam int unsigned IW = clog2(N)
) (
    input  logic [N-1:0]  e,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] pick,
    output logic          any
);

    logic [IW-1:0] idx;

    always_comb begin
        pick = '0;
        any  = 1'b0;
        idx  = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = IW'((32'(last) + i) % N);
            if (!any && e[idx]) begin
                pick = idx;
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wrr_bus_scheduler.sv
// Weighted round-robin bus scheduler: grants one requester for up to weight[i]
// beats, inserts a one-cycle turnaround gap, and revokes stalled grants via a watchdog.
module wrr_bus_scheduler
    import bus_sched_pkg::*;
#(
    parameter  int unsigned N  = DEF_N,
    parameter  int unsigned CW = DEF_CW,
    parameter  int unsigned TO = DEF_TO,
    localparam int unsigned IW = clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*CW-1:0] weight,
    input  logic            beat,
    output logic [N-1:0]    gnt,
    output logic            gnt_valid,
    output logic [IW-1:0]   gnt_id,
    output logic            timeout_err
);

    localparam int unsigned WW = clog2(TO + 1);
    localparam logic [WW-1:0] TO_W = WW'(TO);

    sched_state_e  state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] gnt_id_q, gnt_id_d;
    logic [IW-1:0] last_q, last_d;
    logic [CW-1:0] credit_q, credit_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          timeout_err_q, timeout_err_d;

    logic [N-1:0]  eligible;
    logic [IW-1:0] pick;
    logic          pick_any;
    logic          stall_hit;

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < N; i++) begin
            eligible[i] = req[i] && (weight[i*CW +: CW] != '0);
        end
    end

    rr_pick #(.N(N)) u_pick (
        .e    (eligible),
        .last (last_q),
        .pick (pick),
        .any  (pick_any)
    );

    assign stall_hit = (wdog_q == TO_W) && !beat;

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        gnt_id_d      = gnt_id_q;
        last_d        = last_q;
        credit_d      = credit_q;
        wdog_d        = wdog_q;
        timeout_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d    = {{(N-1){1'b0}}, 1'b1} << pick;
                    gnt_id_d = pick;
                    last_d   = pick;
                    credit_d = weight[32'(pick)*CW +: CW];
                    wdog_d   = '0;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                if (beat) begin
                    credit_d = credit_q - 1'b1;
                    wdog_d   = '0;
                end else begin
                    wdog_d   = wdog_q + 1'b1;
                end
                // Any release cause ends the grant once; only a stall raises the error.
                if ((beat && credit_q == CW'(1)) || !req[gnt_id_q] || stall_hit) begin
                    gnt_d         = '0;
                    gnt_id_d      = '0;
                    wdog_d        = '0;
                    timeout_err_d = stall_hit;
                    state_d       = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            gnt_id_q      <= '0;
            last_q        <= IW'(N - 1);
            credit_q      <= '0;
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            gnt_id_q      <= gnt_id_d;
            last_q        <= last_d;
            credit_q      <= credit_d;
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign gnt         = gnt_q;
    assign gnt_valid   = |gnt_q;
    assign gnt_id      = gnt_id_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_wrr_bus_scheduler.sv
// Directed bench for wrr_bus_scheduler (N=4, CW=4, TO=15): arbitration order,
// quanta, disabled requesters, watchdog, abandon and reset behaviour.
module tb_wrr_bus_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] weight;
    logic        beat;
    logic [3:0]  gnt;
    logic        gnt_valid;
    logic [1:0]  gnt_id;
    logic        timeout_err;

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned fails  = 0;

    wrr_bus_scheduler #(.N(4), .CW(4), .TO(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .weight      (weight),
        .beat        (beat),
        .gnt         (gnt),
        .gnt_valid   (gnt_valid),
        .gnt_id      (gnt_id),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] eg, input logic [1:0] eid,
                           input logic eto);
        chk({tag, ".gnt"},   32'(gnt),         32'(eg));
        chk({tag, ".valid"}, 32'(gnt_valid),   32'(|eg));
        chk({tag, ".id"},    32'(gnt_id),      32'(eid));
        chk({tag, ".to"},    32'(timeout_err), 32'(eto));
    endtask

    initial begin
        rst = 1'b1; req = '0; weight = '0; beat = 1'b0;

        // T1: unit weights, all requesting, beat every cycle -> 0,1,2,3,0
        tick();
        chk_out("t1_reset", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0; req = 4'b1111; weight = 16'h1111; beat = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick(); chk_out("t1_grant", 4'b0001 << (k % 4), 2'(k % 4), 1'b0);
            tick(); chk_out("t1_release", 4'b0000, 2'd0, 1'b0);
            tick(); chk_out("t1_gap", 4'b0000, 2'd0, 1'b0);
        end

        // T2: w0=3, req 0/1 -> gnt0 for 3 beats, gnt1 for 1, then gnt0
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b0011; weight = 16'h1113; beat = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(); chk_out("t2_own0", 4'b0001, 2'd0, 1'b0);
        end
        tick(); chk_out("t2_rel0", 4'b0000, 2'd0, 1'b0);
        tick(); chk_out("t2_gap0", 4'b0000, 2'd0, 1'b0);
        tick(); chk_out("t2_own1", 4'b0010, 2'd1, 1'b0);
        tick(); chk_out("t2_rel1", 4'b0000, 2'd0, 1'b0);
        tick(); chk_out("t2_gap1", 4'b0000, 2'd0, 1'b0);
        tick(); chk_out("t2_own0b", 4'b0001, 2'd0, 1'b0);
        req = 4'b0000; beat = 1'b0;
        tick(); chk_out("t2_abandon", 4'b0000, 2'd0, 1'b0);
        tick();

        // T3: disabled requester never granted until its weight becomes nonzero
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b0010; weight = 16'h1101; beat = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick(); chk_out("t3_disabled", 4'b0000, 2'd0, 1'b0);
        end
        weight = 16'h1121; beat = 1'b0;
        tick(); chk_out("t3_enabled", 4'b0010, 2'd1, 1'b0);
        req = 4'b0000;
        tick(); chk_out("t3_rel", 4'b0000, 2'd0, 1'b0);
        tick();

        // T4: requester 2 stalls with no beat -> watchdog revoke after 16 cycles
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b0100; weight = 16'h1111; beat = 1'b0;
        tick(); chk_out("t4_grant2", 4'b0100, 2'd2, 1'b0);
        req = 4'b0101;
        for (int k = 0; k < 15; k++) begin
            tick(); chk_out("t4_stall", 4'b0100, 2'd2, 1'b0);
        end
        tick(); chk_out("t4_timeout", 4'b0000, 2'd0, 1'b1);
        tick(); chk_out("t4_gap", 4'b0000, 2'd0, 1'b0);
        tick(); chk_out("t4_next0", 4'b0001, 2'd0, 1'b0);
        req = 4'b0000;
        tick(); chk_out("t4_rel", 4'b0000, 2'd0, 1'b0);
        tick();

        // T5: owner abandons during a beat with credit 2; pointer moves past it
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b0011; weight = 16'h2222; beat = 1'b0;
        tick(); chk_out("t5_grant0", 4'b0001, 2'd0, 1'b0);
        req = 4'b0010; beat = 1'b1;
        tick(); chk_out("t5_abandon", 4'b0000, 2'd0, 1'b0);
        req = 4'b0011;
        tick(); chk_out("t5_gap", 4'b0000, 2'd0, 1'b0);
        tick(); chk_out("t5_own1", 4'b0010, 2'd1, 1'b0);
        tick(); chk_out("t5_own1b", 4'b0010, 2'd1, 1'b0);
        tick(); chk_out("t5_rel1", 4'b0000, 2'd0, 1'b0);
        tick(); chk_out("t5_gap1", 4'b0000, 2'd0, 1'b0);
        tick(); chk_out("t5_own0", 4'b0001, 2'd0, 1'b0);

        // T6: reset mid-grant clears outputs; requester 0 first afterwards
        req = 4'b1111; rst = 1'b1;
        tick(); chk_out("t6_reset", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        tick(); chk_out("t6_first0", 4'b0001, 2'd0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
